// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl_pkg
//  Brief    : Shared opcodes, FSM state codes and helpers for the iterative
//             multiply/divide sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_ctrl_pkg;

    // Iteration count of the datapath (one bit of result per step)
    localparam int MD_STEPS = 32;

    // Operation codes, taken from the function field beside ALU control
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_PREP = 2'b01,
        MD_RUN  = 2'b10,
        MD_FIX  = 2'b11
    } md_state_t;

    // Signed variants need magnitude extraction and sign correction
    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Divide variants run the restoring-divide step
    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Brief    : One combinational iteration of the shared multiply/divide
//             datapath. Multiply: conditional add then 2W-bit right shift.
//             Divide: left shift, trial subtract, quotient bit.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,      // {hi, lo} accumulator
    input  logic [WIDTH-1:0]   i_operand,  // multiplicand or divisor
    input  logic               i_bit,      // multiplier bit or next dividend bit
    input  logic               i_div,      // 1 = divide step, 0 = multiply step
    output logic [2*WIDTH-1:0] o_acc_next,
    output logic               o_q_bit
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem;

    // Both step flavours computed in parallel; mode picks the result.
    // For divide the quotient slot (bit 0) is left clear for the caller.
    always_comb begin
        w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_bit ? {1'b0, i_operand} : '0);
        w_shift    = {i_acc[2*WIDTH-1:WIDTH], i_bit};
        w_ge       = (w_shift >= {1'b0, i_operand});
        // Only used when w_ge, where the true difference fits in WIDTH bits
        w_diff     = w_shift[WIDTH-1:0] - i_operand;
        w_rem      = w_ge ? w_diff : w_shift[WIDTH-1:0];
        o_q_bit    = i_div & w_ge;
        o_acc_next = {w_sum, i_acc[WIDTH-1:1]};
        if (i_div) begin
            o_acc_next = {w_rem, i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Brief    : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Runs
//             IDLE -> PREP -> RUN (WIDTH steps) -> FIX and raises Busy_O so
//             the pipeline stalls HI/LO readers and new mul/div instructions.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = MD_STEPS
) (
    input  logic             clk_I,
    input  logic             rstn_I,
    input  logic             Start_I,
    input  logic [1:0]       Op_I,
    input  logic [WIDTH-1:0] A_I,
    input  logic [WIDTH-1:0] B_I,
    input  logic             Kill_I,
    input  logic             HiWe_I,
    input  logic             LoWe_I,
    input  logic [WIDTH-1:0] WData_I,
    output logic             Busy_O,
    output logic             Done_O,
    output logic [WIDTH-1:0] Hi_O,
    output logic [WIDTH-1:0] Lo_O
);

    localparam int                c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    md_state_t           r_state;
    md_state_t           w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          r_op;
    logic [WIDTH-1:0]    r_a;        // raw A until PREP, then |A|
    logic [WIDTH-1:0]    r_b;        // raw B until PREP, then |B|
    logic [WIDTH-1:0]    r_a_raw;    // dividend as issued, for divide-by-zero
    logic [2*WIDTH-1:0]  r_acc;
    logic                r_neg_q;    // quotient / product sign
    logic                r_neg_r;    // remainder sign
    logic                r_dz;       // divisor was zero
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_done;

    logic                w_is_div;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_step_bit;
    logic [WIDTH-1:0]    w_step_opnd;
    logic [2*WIDTH-1:0]  w_acc_next;
    logic                w_q_bit;
    logic [2*WIDTH-1:0]  w_acc_step;
    logic [WIDTH-1:0]    w_fix_hi;
    logic [WIDTH-1:0]    w_fix_lo;

    assign Done_O = r_done;
    assign Hi_O   = r_hi;
    assign Lo_O   = r_lo;

    // State register
    always_ff @(posedge clk_I or negedge rstn_I) begin
        if (!rstn_I) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and busy decode; a kill drops any active state back to idle
    always_comb begin
        w_state_nxt = r_state;
        Busy_O      = (r_state != MD_IDLE);
        case (r_state)
            MD_IDLE: if (Start_I && !Kill_I) w_state_nxt = MD_PREP;
            MD_PREP: w_state_nxt = Kill_I ? MD_IDLE : MD_RUN;
            MD_RUN: begin
                if (Kill_I)              w_state_nxt = MD_IDLE;
                else if (r_cnt == '0)    w_state_nxt = MD_FIX;
            end
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Operand signs and per-step bit selection (multiplier LSB-first,
    // dividend MSB-first, both indexed from the down-counter)
    always_comb begin
        w_is_div    = md_is_div(r_op);
        w_a_neg     = md_is_signed(r_op) & r_a[WIDTH-1];
        w_b_neg     = md_is_signed(r_op) & r_b[WIDTH-1];
        w_step_bit  = w_is_div ? r_a[r_cnt] : r_b[c_last - r_cnt];
        w_step_opnd = w_is_div ? r_b : r_a;
        w_acc_step  = {w_acc_next[2*WIDTH-1:1], w_is_div ? w_q_bit : w_acc_next[0]};
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc      (r_acc),
        .i_operand  (w_step_opnd),
        .i_bit      (w_step_bit),
        .i_div      (w_is_div),
        .o_acc_next (w_acc_next),
        .o_q_bit    (w_q_bit)
    );

    // Sign correction of the raw magnitude result; divide-by-zero bypasses it
    always_comb begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
        if (!w_is_div) begin
            if (r_neg_q) {w_fix_hi, w_fix_lo} = -r_acc;
        end else if (r_dz) begin
            w_fix_hi = r_a_raw;
            w_fix_lo = '1;
        end else begin
            if (r_neg_q) w_fix_lo = -r_acc[WIDTH-1:0];
            if (r_neg_r) w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
        end
    end

    // Operand capture, iteration datapath, HI/LO and done pulse
    always_ff @(posedge clk_I or negedge rstn_I) begin
        if (!rstn_I) begin
            r_cnt   <= '0;
            r_op    <= MD_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_a_raw <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (HiWe_I) r_hi <= WData_I;
                    if (LoWe_I) r_lo <= WData_I;
                    if (Start_I && !Kill_I) begin
                        r_op    <= Op_I;
                        r_a     <= A_I;
                        r_b     <= B_I;
                        r_a_raw <= A_I;
                    end
                end
                MD_PREP: begin
                    r_a     <= w_a_neg ? -r_a : r_a;
                    r_b     <= w_b_neg ? -r_b : r_b;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_dz    <= (r_b == '0);
                    r_cnt   <= c_last;
                    r_acc   <= '0;
                end
                MD_RUN: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt - c_one;
                end
                MD_FIX: begin
                    if (!Kill_I) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Brief    : Self-checking bench for muldiv_ctrl: transaction-level model
//             compared every cycle, plus hand-computed directed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start, kill, hiwe, lowe;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk_I   (clk),
        .rstn_I  (rstn),
        .Start_I (start),
        .Op_I    (op),
        .A_I     (a),
        .B_I     (b),
        .Kill_I  (kill),
        .HiWe_I  (hiwe),
        .LoWe_I  (lowe),
        .WData_I (wdata),
        .Busy_O  (busy),
        .Done_O  (done),
        .Hi_O    (hi),
        .Lo_O    (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic
    function automatic void model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                         output logic [31:0] rh, output logic [31:0] rl);
        longint sx, sy, p, q, r;
        logic [63:0] up;
        sx = $signed(x);
        sy = $signed(y);
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin up = {32'h0, x} * {32'h0, y}; rh = up[63:32]; rl = up[31:0]; end
            2'b10: begin
                if (y == 0) begin rh = x; rl = '1; end
                else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
            end
            default: begin
                if (y == 0) begin rh = x; rl = '1; end
                else begin rl = x / y; rh = x % y; end
            end
        endcase
    endfunction

    // Transaction model: an accepted start is busy for 34 cycles, then
    // HI/LO take the result with a one-cycle done pulse
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (kill) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_hi = m_rhi; m_lo = m_rlo; m_done = 1'b1; end
                end
            end else begin
                if (hiwe) m_hi = wdata;
                if (lowe) m_lo = wdata;
                if (start && !kill) begin
                    model_result(op, a, b, m_rhi, m_rlo);
                    m_left = 34;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {63'b0, busy}, {63'b0, (m_left > 0)});
            chk("done", {63'b0, done}, {63'b0, m_done});
            chk("hi", {32'b0, hi}, {32'b0, m_hi});
            chk("lo", {32'b0, lo}, {32'b0, m_lo});
        end
    end

    // Called at posedge+2; returns at posedge+2 of cycle 1 (edge 0 sampled start)
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    // From cycle 1: checks busy in cycle 34 and the result in cycle 35
    task automatic expect_done(input string name, input logic [31:0] eh, input logic [31:0] el);
        repeat (33) @(posedge clk);
        #1 chk({name, "_busy34"}, {63'b0, busy}, 64'd1);
        @(posedge clk);
        #1;
        chk({name, "_busy35"}, {63'b0, busy}, 64'd0);
        chk({name, "_done"}, {63'b0, done}, 64'd1);
        chk({name, "_hi"}, {32'b0, hi}, {32'b0, eh});
        chk({name, "_lo"}, {32'b0, lo}, {32'b0, el});
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; kill = 1'b0; hiwe = 1'b0; lowe = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        @(posedge clk); #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);

        // Preload HI/LO
        hiwe = 1'b1; wdata = 32'hAAAA5555;
        idle(1);
        hiwe = 1'b0; lowe = 1'b1; wdata = 32'h0000_1234;
        idle(1);
        lowe = 1'b0;
        chk("mthi", {32'b0, hi}, 64'hAAAA5555);
        chk("mtlo", {32'b0, lo}, 64'h1234);

        // Kill blocks a start in idle
        kill = 1'b1;
        launch(2'b00, 32'd5, 32'd7);
        kill = 1'b0;
        chk("kill_blocks_start", {63'b0, busy}, 64'd0);
        idle(2);

        // MULT with MTHI while busy, killed at cycle 10
        launch(2'b00, 32'd5, 32'd7);
        chk("kill_busy1", {63'b0, busy}, 64'd1);
        idle(3);
        hiwe = 1'b1; wdata = 32'hDEADBEEF;
        idle(1);
        hiwe = 1'b0;
        idle(5);
        kill = 1'b1;
        @(posedge clk);
        #1;
        chk("kill_busy11", {63'b0, busy}, 64'd0);
        chk("kill_hi", {32'b0, hi}, 64'hAAAA5555);
        chk("kill_lo", {32'b0, lo}, 64'h1234);
        #1 kill = 1'b0;
        idle(30);
        chk("kill_hi_late", {32'b0, hi}, 64'hAAAA5555);

        // Directed results, the later ones launched in the previous done cycle
        launch(2'b00, 32'hFFFFFFFE, 32'd3);
        expect_done("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        idle(2);
        launch(2'b01, 32'hFFFFFFFE, 32'd3);
        expect_done("multu", 32'h00000002, 32'hFFFFFFFA);
        launch(2'b11, 32'd100, 32'd7);
        expect_done("divu", 32'h00000002, 32'h0000000E);
        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        expect_done("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        launch(2'b10, 32'd7, 32'hFFFFFFFE);
        expect_done("div_negb", 32'h00000001, 32'hFFFFFFFD);
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        expect_done("div_ovf", 32'h00000000, 32'h80000000);
        idle(3);
        launch(2'b10, 32'h12345678, 32'd0);
        expect_done("div_zero", 32'h12345678, 32'hFFFFFFFF);
        launch(2'b01, 32'h00010000, 32'h00010000);
        expect_done("b2b_multu", 32'h00000001, 32'h00000000);
        idle(2);

        // MTHI in the start cycle is applied, then overwritten by the result
        hiwe = 1'b1; wdata = 32'h0BAD0BAD;
        launch(2'b11, 32'd9, 32'd4);
        hiwe = 1'b0;
        chk("mthi_start", {32'b0, hi}, 64'h0BAD0BAD);
        expect_done("divu_small", 32'd1, 32'd2);
        idle(2);

        // Model-checked vectors, with a spurious start pulsed while busy
        for (int i = 0; i < 4; i++) begin
            launch(2'(i), $urandom, (i == 3) ? 32'($urandom_range(1, 1000)) : $urandom);
            idle(8);
            op = 2'(i + 1); a = $urandom; b = $urandom; start = 1'b1;
            idle(1);
            start = 1'b0;
            idle(30);
        end

        // Asynchronous reset at cycle 20 of a DIVU
        launch(2'b11, 32'd100, 32'd7);
        idle(19);
        #1 rstn = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        chk("arst_hi", {32'b0, hi}, 64'd0);
        chk("arst_lo", {32'b0, lo}, 64'd0);
        @(posedge clk); #2 rstn = 1'b1;
        idle(1);
        launch(2'b11, 32'd1000, 32'd10);
        expect_done("post_rst", 32'd0, 32'd100);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
